// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory bridge: FSM states, one-hot
// size encodings and the byte-count decode used by both load and store paths.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic [3:0] SZ_LB  = 4'b1000;
    localparam logic [3:0] SZ_LBU = 4'b0100;
    localparam logic [3:0] SZ_LH  = 4'b0010;
    localparam logic [3:0] SZ_LHU = 4'b0001;
    localparam logic [3:0] SZ_W   = 4'b0000;

    // Number of SRAM bytes touched by a request; anything that is not a clean
    // one-hot byte/half code falls back to a full word.
    function automatic logic [2:0] byte_count(input logic [3:0] mem_size);
        logic [2:0] n;
        case (mem_size)
            SZ_LB, SZ_LBU: n = 3'd1;
            SZ_LH, SZ_LHU: n = 3'd2;
            default:       n = 3'd4;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mem_bridge_if.sv
// CPU-side request/response bundle between the control sequencer (master)
// and the memory bridge (slave).
interface mem_bridge_if;

    logic [31:0] addr;
    logic [31:0] bus;
    logic [31:0] bus_out;
    logic        bus_drive;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mem_size;
    logic        mem_addr_ready;
    logic        mem_data_ready;
    logic        busy;

    modport master (
        output addr, bus, mem_read, mem_write, mem_size, mem_addr_ready,
        input  bus_out, bus_drive, mem_data_ready, busy
    );

    modport slave (
        input  addr, bus, mem_read, mem_write, mem_size, mem_addr_ready,
        output bus_out, bus_drive, mem_data_ready, busy
    );

endinterface

// File: rtl/load_extend.sv
// Turns the raw little-endian word collected from the SRAM into the value the
// CPU expects for the requested load width, applying sign or zero extension.
module load_extend
    import mem_pkg::*;
(
    input  logic [31:0] raw_i,
    input  logic [3:0]  mem_size_i,
    output logic [31:0] result_o
);

    // Pick the extension rule from the one-hot size code; words pass through.
    always_comb begin
        result_o = raw_i;
        case (mem_size_i)
            SZ_LB:   result_o = {{24{raw_i[7]}}, raw_i[7:0]};
            SZ_LBU:  result_o = {24'd0, raw_i[7:0]};
            SZ_LH:   result_o = {{16{raw_i[15]}}, raw_i[15:0]};
            SZ_LHU:  result_o = {16'd0, raw_i[15:0]};
            default: result_o = raw_i;
        endcase
    end

endmodule

// File: rtl/mem_bridge.sv
// Bridge from 32-bit CPU loads/stores to byte-serial accesses on an 8-bit
// asynchronous-read SRAM. Stores are posted into a one-entry buffer and
// drained before any further read is started, which keeps read-after-write
// ordering without a forwarding path.
module mem_bridge
    import mem_pkg::*;
#(
    parameter int ADDR_W = 19
) (
    input  logic              clk,
    input  logic              reset,
    mem_bridge_if.slave       cpu,
    output logic [ADDR_W-1:0] sram_addr,
    input  logic [7:0]        sram_dout,
    output logic [7:0]        sram_din,
    output logic              sram_we,
    output logic              sram_oe
);

    state_e            state_q, state_d;
    logic [1:0]        k_q, k_d;

    logic              wbValid_q, wbValid_d;
    logic [ADDR_W-1:0] wbAddr_q, wbAddr_d;
    logic [31:0]       wbData_q, wbData_d;
    logic [2:0]        wbN_q, wbN_d;

    logic [ADDR_W-1:0] rdAddr_q, rdAddr_d;
    logic [3:0]        rdSize_q, rdSize_d;
    logic [31:0]       rdBuf_q, rdBuf_d;
    logic [31:0]       busOut_q, busOut_d;

    logic [2:0]        rdN;
    logic              lastRd;
    logic              lastWr;
    logic [31:0]       extResult;
    logic              unusedAddrHi;

    assign unusedAddrHi = ^cpu.addr[31:ADDR_W];

    assign rdN    = byte_count(rdSize_q);
    assign lastRd = ({1'b0, k_q} == (rdN - 3'd1));
    assign lastWr = ({1'b0, k_q} == (wbN_q - 3'd1));

    load_extend uExtend (
        .raw_i      (rdBuf_q),
        .mem_size_i (rdSize_q),
        .result_o   (extResult)
    );

    assign cpu.busy    = (state_q != IDLE) || wbValid_q;
    assign cpu.bus_out = (state_q == DONE) ? extResult : busOut_q;

    // Register all bridge state; reset abandons any transfer in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            k_q       <= '0;
            wbValid_q <= 1'b0;
            wbAddr_q  <= '0;
            wbData_q  <= '0;
            wbN_q     <= '0;
            rdAddr_q  <= '0;
            rdSize_q  <= '0;
            rdBuf_q   <= '0;
            busOut_q  <= '0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            wbValid_q <= wbValid_d;
            wbAddr_q  <= wbAddr_d;
            wbData_q  <= wbData_d;
            wbN_q     <= wbN_d;
            rdAddr_q  <= rdAddr_d;
            rdSize_q  <= rdSize_d;
            rdBuf_q   <= rdBuf_d;
            busOut_q  <= busOut_d;
        end
    end

    // Next-state and SRAM/CPU strobes: write capture runs in every state,
    // then the FSM walks one byte per cycle through the active transfer.
    always_comb begin
        state_d            = state_q;
        k_d                = k_q;
        wbValid_d          = wbValid_q;
        wbAddr_d           = wbAddr_q;
        wbData_d           = wbData_q;
        wbN_d              = wbN_q;
        rdAddr_d           = rdAddr_q;
        rdSize_d           = rdSize_q;
        rdBuf_d            = rdBuf_q;
        busOut_d           = busOut_q;
        sram_addr          = '0;
        sram_din           = '0;
        sram_we            = 1'b0;
        sram_oe            = 1'b0;
        cpu.mem_data_ready = 1'b0;
        cpu.bus_drive      = 1'b0;

        if (cpu.mem_write && !wbValid_q) begin
            wbValid_d = 1'b1;
            wbAddr_d  = cpu.addr[ADDR_W-1:0];
            wbData_d  = cpu.bus;
            wbN_d     = byte_count(cpu.mem_size);
        end

        case (state_q)
            IDLE: begin
                if (wbValid_q || cpu.mem_write) begin
                    state_d = WR;
                    k_d     = '0;
                end else if (cpu.mem_read && cpu.mem_addr_ready) begin
                    rdAddr_d = cpu.addr[ADDR_W-1:0];
                    rdSize_d = cpu.mem_size;
                    state_d  = RD;
                    k_d      = '0;
                end
            end
            WR: begin
                sram_addr = wbAddr_q + ADDR_W'(k_q);
                sram_din  = wbData_q[{k_q, 3'b000} +: 8];
                sram_we   = 1'b1;
                if (lastWr) begin
                    wbValid_d = 1'b0;
                    state_d   = IDLE;
                    k_d       = '0;
                end else begin
                    k_d = k_q + 2'd1;
                end
            end
            RD: begin
                sram_addr = rdAddr_q + ADDR_W'(k_q);
                sram_oe   = 1'b1;
                rdBuf_d[{k_q, 3'b000} +: 8] = sram_dout;
                if (lastRd) begin
                    state_d = DONE;
                    k_d     = '0;
                end else begin
                    k_d = k_q + 2'd1;
                end
            end
            DONE: begin
                cpu.mem_data_ready = 1'b1;
                cpu.bus_drive      = 1'b1;
                busOut_d           = extResult;
                state_d            = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_bridge.sv
// Directed bench for mem_bridge: drives the CPU side through the interface,
// models the byte SRAM locally and checks results against hand-computed values.
module tb_mem_bridge;

    localparam int ADDR_W = 19;

    logic              clk;
    logic              reset;
    logic [ADDR_W-1:0] sram_addr;
    logic [7:0]        sram_dout;
    logic [7:0]        sram_din;
    logic              sram_we;
    logic              sram_oe;

    logic [7:0] sramMem [0:(1 << ADDR_W) - 1];

    int total = 0;
    int bad   = 0;

    int                latency;
    logic [31:0]       readData;
    logic              driveAtReady;
    logic              gotReady;
    int                busyLow;
    logic [ADDR_W-1:0] oeAddr [$];
    logic [ADDR_W-1:0] weAddr [$];
    logic [7:0]        weData [$];

    mem_bridge_if cpuIf ();

    mem_bridge #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu       (cpuIf),
        .sram_addr (sram_addr),
        .sram_dout (sram_dout),
        .sram_din  (sram_din),
        .sram_we   (sram_we),
        .sram_oe   (sram_oe)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural sram8: combinational read, write on posedge while strobed.
    assign sram_dout = sramMem[sram_addr];
    always @(posedge clk) begin
        if (sram_we) sramMem[sram_addr] <= sram_din;
    end

    // Hard stop if the sequence ever wedges.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue a read and hold it like the sequencer does until mem_data_ready,
    // logging SRAM activity along the way. Cycle 0 is the issuing cycle.
    task automatic applyStimulus(input logic [31:0] a, input logic [3:0] sz);
        oeAddr.delete();
        weAddr.delete();
        weData.delete();
        busyLow      = 0;
        gotReady     = 1'b0;
        latency      = -1;
        readData     = '0;
        driveAtReady = 1'b0;
        cpuIf.addr           = a;
        cpuIf.mem_size       = sz;
        cpuIf.mem_read       = 1'b1;
        cpuIf.mem_addr_ready = 1'b1;
        for (int c = 0; c < 40 && !gotReady; c++) begin
            if (sram_oe) oeAddr.push_back(sram_addr);
            if (sram_we) begin
                weAddr.push_back(sram_addr);
                weData.push_back(sram_din);
            end
            if ((sram_oe || sram_we || cpuIf.mem_data_ready) && !cpuIf.busy) busyLow++;
            if (cpuIf.mem_data_ready) begin
                gotReady             = 1'b1;
                latency              = c;
                readData             = cpuIf.bus_out;
                driveAtReady         = cpuIf.bus_drive;
                cpuIf.mem_read       = 1'b0;
                cpuIf.mem_addr_ready = 1'b0;
            end else begin
                tick();
            end
        end
        cpuIf.mem_read       = 1'b0;
        cpuIf.mem_addr_ready = 1'b0;
    endtask

    task automatic checkRead(input string tag, input logic [31:0] a, input logic [3:0] sz,
                             input logic [31:0] expData, input int expLat);
        applyStimulus(a, sz);
        checkOutput({tag, "_ready"}, 32'(gotReady), 32'd1);
        checkOutput({tag, "_data"}, readData, expData);
        checkOutput({tag, "_latency"}, 32'(latency), 32'(expLat));
        checkOutput({tag, "_drive"}, 32'(driveAtReady), 32'd1);
        tick();
        checkOutput({tag, "_pulse"}, {30'd0, cpuIf.mem_data_ready, cpuIf.bus_drive}, 32'd0);
        checkOutput({tag, "_hold"}, cpuIf.bus_out, expData);
    endtask

    initial begin
        int readySeen;

        reset                = 1'b0;
        cpuIf.addr           = '0;
        cpuIf.bus            = '0;
        cpuIf.mem_read       = 1'b0;
        cpuIf.mem_write      = 1'b0;
        cpuIf.mem_size       = 4'b0000;
        cpuIf.mem_addr_ready = 1'b0;

        sramMem[19'h00100] <= 8'h78;
        sramMem[19'h00101] <= 8'h56;
        sramMem[19'h00102] <= 8'h34;
        sramMem[19'h00103] <= 8'h12;
        sramMem[19'h00200] <= 8'h80;
        sramMem[19'h00300] <= 8'h34;
        sramMem[19'h00301] <= 8'h92;
        sramMem[19'h7FFFE] <= 8'h11;
        sramMem[19'h7FFFF] <= 8'h22;
        sramMem[19'h00000] <= 8'h33;
        sramMem[19'h00001] <= 8'h44;

        tick();
        tick();
        checkOutput("rst_bus_out", cpuIf.bus_out, 32'h0);
        checkOutput("rst_flags", {26'd0, cpuIf.mem_data_ready, cpuIf.bus_drive, cpuIf.busy,
                    sram_we, sram_oe, 1'b0}, 32'h0);
        checkOutput("rst_sram_addr", 32'(sram_addr), 32'h0);
        checkOutput("rst_sram_din", 32'(sram_din), 32'h0);
        reset = 1'b1;
        tick();

        checkRead("word100", 32'h100, 4'b0000, 32'h12345678, 5);
        checkOutput("word100_naddr", 32'(oeAddr.size()), 32'd4);
        if (oeAddr.size() == 4) begin
            checkOutput("word100_a0", 32'(oeAddr[0]), 32'h100);
            checkOutput("word100_a1", 32'(oeAddr[1]), 32'h101);
            checkOutput("word100_a2", 32'(oeAddr[2]), 32'h102);
            checkOutput("word100_a3", 32'(oeAddr[3]), 32'h103);
        end
        checkOutput("word100_busy", 32'(busyLow), 32'd0);

        checkRead("lb200", 32'h200, 4'b1000, 32'hFFFFFF80, 2);
        checkRead("lbu200", 32'h200, 4'b0100, 32'h00000080, 2);
        checkRead("lh300", 32'h300, 4'b0010, 32'hFFFF9234, 3);
        checkRead("lhu300", 32'h300, 4'b0001, 32'h00009234, 3);

        cpuIf.addr      = 32'h400;
        cpuIf.bus       = 32'hDEADBEEF;
        cpuIf.mem_size  = 4'b0000;
        cpuIf.mem_write = 1'b1;
        tick();
        cpuIf.mem_write = 1'b0;
        cpuIf.bus       = 32'h0;
        checkOutput("wr_busy_start", 32'(cpuIf.busy), 32'd1);
        checkRead("raw400", 32'h400, 4'b0000, 32'hDEADBEEF, 9);
        checkOutput("raw400_nwe", 32'(weAddr.size()), 32'd4);
        if (weAddr.size() == 4) begin
            checkOutput("raw400_w0", {5'd0, weAddr[0], weData[0]}, {5'd0, 19'h400, 8'hEF});
            checkOutput("raw400_w1", {5'd0, weAddr[1], weData[1]}, {5'd0, 19'h401, 8'hBE});
            checkOutput("raw400_w2", {5'd0, weAddr[2], weData[2]}, {5'd0, 19'h402, 8'hAD});
            checkOutput("raw400_w3", {5'd0, weAddr[3], weData[3]}, {5'd0, 19'h403, 8'hDE});
        end
        checkOutput("raw400_busy", 32'(busyLow), 32'd0);
        checkOutput("raw400_noread_wr", 32'(oeAddr.size()), 32'd4);

        checkRead("wrap", 32'h7FFFE, 4'b0000, 32'h44332211, 5);
        checkOutput("wrap_naddr", 32'(oeAddr.size()), 32'd4);
        if (oeAddr.size() == 4) begin
            checkOutput("wrap_a0", 32'(oeAddr[0]), 32'h7FFFE);
            checkOutput("wrap_a1", 32'(oeAddr[1]), 32'h7FFFF);
            checkOutput("wrap_a2", 32'(oeAddr[2]), 32'h00000);
            checkOutput("wrap_a3", 32'(oeAddr[3]), 32'h00001);
        end

        cpuIf.addr           = 32'h100;
        cpuIf.mem_size       = 4'b0000;
        cpuIf.mem_read       = 1'b1;
        cpuIf.mem_addr_ready = 1'b1;
        tick();
        cpuIf.mem_read       = 1'b0;
        cpuIf.mem_addr_ready = 1'b0;
        tick();
        tick();
        checkOutput("midrst_byte2", {31'd0, sram_oe} | (32'(sram_addr) << 4), (32'h102 << 4) | 32'd1);
        reset = 1'b0;
        tick();
        checkOutput("midrst_bus_out", cpuIf.bus_out, 32'h0);
        checkOutput("midrst_flags", {26'd0, cpuIf.mem_data_ready, cpuIf.bus_drive, cpuIf.busy,
                    sram_we, sram_oe, 1'b0}, 32'h0);
        checkOutput("midrst_sram", {5'd0, sram_addr, sram_din}, 32'h0);
        reset = 1'b1;
        readySeen = 0;
        for (int i = 0; i < 8; i++) begin
            if (cpuIf.mem_data_ready || cpuIf.busy) readySeen++;
            tick();
        end
        checkOutput("midrst_quiet", 32'(readySeen), 32'd0);
        checkRead("postrst_lbu", 32'h200, 4'b0100, 32'h00000080, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_bridge.md
Name: mem_bridge

Overview:
- Sits directly downstream of the control sequencer's memory interface.
- Turns 32-bit CPU load, store and fetch requests into little-endian byte accesses on an 8-bit asynchronous-read SRAM.
- Returns assembled and extended load data on the shared bus with a one-cycle mem_data_ready pulse.
- Stores are posted through a one-entry write buffer, because the sequencer does not wait on writes; a following read is held off until the buffer drains.

Parameters:
- ADDR_W, 19: SRAM byte-address width; request address bits above ADDR_W-1 are ignored.

Ports:
- clk  in  1  system clock, posedge.
- reset  in  1  synchronous, active-low reset.
- addr  in  32  request byte address.
- bus  in  32  store data.
- bus_out  out  32  load/fetch result.
- bus_drive  out  1  bus_out valid for the bus mux.
- mem_read  in  1  read request level.
- mem_write  in  1  write request, single-cycle pulse.
- mem_size  in  4  {lb, lbu, lh, lhu} one-hot; 0 = word.
- mem_addr_ready  in  1  read address valid (registered by sequencer).
- mem_data_ready  out  1  read complete, one-cycle pulse.
- busy  out  1  state != IDLE or write buffer occupied.
- sram_addr  out  ADDR_W  byte address.
- sram_dout  in  8  SRAM read data, combinational from sram_addr.
- sram_din  out  8  SRAM write data.
- sram_we  out  1  byte write strobe; SRAM writes on posedge while high.
- sram_oe  out  1  read enable.

Behaviour:
- Reset (reset==0 at posedge):
  - State goes to IDLE; write buffer and read buffer are cleared.
  - All outputs go to 0: mem_data_ready, bus_drive, busy, sram_we, sram_oe, sram_addr, sram_din, bus_out.
- Byte count n: mem_size==0 gives 4; mem_size[1] or [0] gives 2; mem_size[3] or [2] gives 1. Any other nonzero mem_size is treated as word.
- Write capture:
  - mem_write==1 in any state while the write buffer is empty latches addr, bus and n into the buffer. mem_write needs no mem_addr_ready.
  - mem_write while the buffer is full is a protocol error; it is dropped and the bench asserts on it.
- IDLE priority:
  - Write buffer full: go to WR, k=0.
  - Else if mem_read && mem_addr_ready: latch addr and mem_size, go to RD, k=0.
  - A write captured in the same cycle as a read request wins; the read is re-sampled later, since mem_addr_ready stays high while the sequencer waits.
- WR, per cycle:
  - sram_addr = (base+k) mod 2^ADDR_W, sram_din = data[8k+7:8k], sram_we=1.
  - k increments; after byte n-1, free the buffer and go to IDLE.
  - No mem_data_ready is produced for writes.
- RD, per cycle:
  - sram_addr = base+k, sram_oe=1; sram_dout is captured into byte lane k at posedge.
  - After byte n-1, go to DONE.
- DONE, exactly one cycle:
  - mem_data_ready=1, bus_drive=1.
  - bus_out = extended result: lb sign-extends bit 7, lbu zero-extends, lh sign-extends bit 15, lhu zero-extends, word passes through.
  - Next state is IDLE. The sequencer drops mem_addr_ready for at least that cycle, so a request is never double-serviced.
- Latency:
  - Read accepted at posedge T gives mem_data_ready during cycle T+n+1: word 5 cycles after acceptance, byte 2.
  - A read behind a pending write waits an extra n_w cycles.
- Wrap: byte address base+k wraps modulo 2^ADDR_W. Misaligned requests are performed byte by byte anyway, since the sequencer traps them beforehand.
- Read-after-write ordering is guaranteed by the drain-first rule, so no forwarding path exists.
- Reset mid-transfer: the transfer is abandoned. Bytes already written stay in the SRAM; no mem_data_ready follows.
- bus_out outside DONE is held at its last value, with bus_drive=0.

Decomposition:
- mem_pkg holds:
  - the state enum {IDLE, WR, RD, DONE};
  - size-decode constants SZ_LB=4'b1000, SZ_LBU=4'b0100, SZ_LH=4'b0010, SZ_LHU=4'b0001, SZ_W=4'b0000;
  - function byte_count(mem_size).
- One sub-module, load_extend: combinational 32-bit raw word plus mem_size to the extended result, unit-tested on its own.
- The SRAM behavioural model (sram8) is bench-only.

Test Plan:
- SRAM[0x100..0x103]=78 56 34 12; mem_read, mem_size=0, addr=0x100 -> sram_addr steps 0x100..0x103; mem_data_ready one cycle, 5 cycles after accept; bus_out=0x12345678.
- SRAM[0x200]=0x80; lb then lbu at 0x200 -> 0xFFFFFF80 then 0x00000080, each 2 cycles after accept.
- SRAM[0x300..0x301]=0x34 0x92; lh -> 0xFFFF9234; lhu -> 0x00009234.
- mem_write pulse, addr=0x400, bus=0xDEADBEEF, size=0, then mem_read word at 0x400 the next cycle -> four sram_we strobes (EF BE AD DE) first, then the read returns 0xDEADBEEF; busy is high throughout.
- Word read at addr=(2^19)-2 -> bytes from 0x7FFFE, 0x7FFFF, 0x00000, 0x00001.
- reset=0 during RD byte 2 -> next cycle IDLE, all outputs 0, no mem_data_ready; a fresh request afterwards completes normally.
